piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_parity_gen.sv | 14 +
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serializer slice.
// PISO_PARITY_EN (when defined) adds a trailing even-parity bit to every frame.
package piso_pkg;

  localparam int PISO_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_parity_gen.sv
// Even-parity generator: XOR-reduce of a parallel data word.
// Only instantiated when PISO_PARITY_EN is defined.
module piso_parity_gen
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with registered bit stream and frame_done pulse.
// Build option PISO_PARITY_EN appends one even-parity bit (state PARITY) to each frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_done,
  output state_t           o_dbg_state
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_out, w_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             w_last, w_xfer, w_first_bit, w_next_bit;
  logic [WIDTH-1:0] w_load_shift, w_adv_shift;

  // r_shift holds the bits not yet presented, aligned so the next one sits at the exit end.
  assign w_first_bit  = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign w_load_shift = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
  assign w_next_bit   = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_adv_shift  = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

`ifdef PISO_PARITY_EN
  logic w_din_parity;
  logic r_parity;

  piso_parity_gen #(.WIDTH(WIDTH)) u_parity_gen (
    .i_data   (din),
    .o_parity (w_din_parity)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= w_din_parity;
    end
  end

  assign w_last = (r_state == PARITY);
`else
  assign w_last = (r_state == SHIFT) && (r_cnt == LAST_IDX);
`endif

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready is high in IDLE and on the final bit of a frame; held low during reset.
  assign din_ready   = rst && ((r_state == IDLE) || w_last);
  assign w_xfer      = din_valid && din_ready;
  assign frame_done  = w_last;
  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    if (w_xfer) begin
      w_state_nxt     = SHIFT;
      w_shift_nxt     = w_load_shift;
      w_cnt_nxt       = '0;
      w_out_nxt       = w_first_bit;
      w_out_valid_nxt = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_out_nxt       = 1'b0;
          w_out_valid_nxt = 1'b0;
        end
        SHIFT: begin
          if (r_cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            w_state_nxt = PARITY;
            w_out_nxt   = r_parity;
            w_cnt_nxt   = r_cnt + 1'b1;
`else
            w_state_nxt     = IDLE;
            w_out_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
            w_cnt_nxt       = '0;
`endif
          end else begin
            w_shift_nxt = w_adv_shift;
            w_out_nxt   = w_next_bit;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_out_nxt       = 1'b0;
          w_out_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share din/din_valid,
// checked every cycle against a queue model of the expected serial stream.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + (PAR ? 1 : 0);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         m_ready, m_out, m_valid, m_fd;
  logic         l_ready, l_out, l_valid, l_fd;
  state_t       m_state, l_state;
  logic [7:0]   w_obs;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .out(m_out), .out_valid(m_valid), .frame_done(m_fd), .o_dbg_state(m_state)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .out(l_out), .out_valid(l_valid), .frame_done(l_fd), .o_dbg_state(l_state)
  );

  assign w_obs = {m_out, m_valid, m_fd, m_ready, l_out, l_valid, l_fd, l_ready};

  int total = 0;
  int bad   = 0;

  // scoreboard: each entry is {serial bit, last-of-frame}; front = bit on the wire now
  logic [1:0] exp_m_q[$];
  logic [1:0] exp_l_q[$];

  task automatic model_reset();
    exp_m_q.delete();
    exp_l_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic accept;
    accept = rst && din_valid && (exp_m_q.size() <= 1);
    if (exp_m_q.size() > 0) begin
      void'(exp_m_q.pop_front());
      void'(exp_l_q.pop_front());
    end
    if (accept) begin
      for (int i = 0; i < W; i++) begin
        exp_m_q.push_back({din[W-1-i], (i == W-1) && (PAR == 1'b0)});
        exp_l_q.push_back({din[i], (i == W-1) && (PAR == 1'b0)});
      end
      if (PAR) begin
        exp_m_q.push_back({^din, 1'b1});
        exp_l_q.push_back({^din, 1'b1});
      end
    end
  endtask

  function automatic logic [7:0] model_expect();
    logic [3:0] em, el;
    em = 4'b0;
    el = 4'b0;
    if (exp_m_q.size() > 0) em = {exp_m_q[0][1], 1'b1, exp_m_q[0][0], 1'b0};
    if (exp_l_q.size() > 0) el = {exp_l_q[0][1], 1'b1, exp_l_q[0][0], 1'b0};
    em[0] = rst && (exp_m_q.size() <= 1);
    el[0] = em[0];
    return {em, el};
  endfunction

  // driver
  task automatic drive(input logic v, input logic [W-1:0] d);
    din_valid = v;
    din       = d;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    model_reset();
    #1 rst = 1'b0;
    #2;
    total++;
    if (w_obs !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", w_obs, 8'h00);
    end
    total++;
    if (m_state !== IDLE || l_state !== IDLE) begin
      bad++; $display("FAIL reset_state got=%0d/%0d want=%0d", m_state, l_state, IDLE);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp = model_expect();
    total++;
    if (w_obs !== exp) begin
      bad++; $display("FAIL reset_release got=%b want=%b", w_obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame(input logic [W-1:0] word, input logic [W-1:0] ser_m,
                                   input logic [W-1:0] ser_l);
    logic [7:0]   exp;
    logic [W-1:0] col_m, col_l;
    col_m = '0;
    col_l = '0;
    for (int k = 0; k < FL + 3; k++) begin
      drive(k == 0, word);
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL single_%h cyc=%0d got=%b want=%b", word, k, w_obs, exp);
      end
      if (k >= 1 && k <= W) begin
        col_m = {col_m[W-2:0], m_out};
        col_l = {col_l[W-2:0], l_out};
      end
      model_step();
      @(posedge clk); #1;
    end
    total++;
    if (col_m !== ser_m) begin
      bad++; $display("FAIL serial_msb_%h got=%b want=%b", word, col_m, ser_m);
    end
    total++;
    if (col_l !== ser_l) begin
      bad++; $display("FAIL serial_lsb_%h got=%b want=%b", word, col_l, ser_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]    exp;
    logic [2*W-1:0] col_m;
    int            nvalid;
    col_m  = '0;
    nvalid = 0;
    for (int k = 0; k < 2 * FL + 3; k++) begin
      drive(k <= FL, (k == 0) ? 8'hD0 : 8'hDD);
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL b2b cyc=%0d got=%b want=%b", k, w_obs, exp);
      end
      if (m_valid === 1'b1) nvalid++;
      if (m_valid === 1'b1 && m_fd !== 1'b1 && nvalid <= 2 * FL) col_m = {col_m[2*W-2:0], m_out};
      if (m_valid === 1'b1 && m_fd === 1'b1 && PAR == 1'b0) col_m = {col_m[2*W-2:0], m_out};
      model_step();
      @(posedge clk); #1;
    end
    total++;
    if (nvalid != 2 * FL) begin
      bad++; $display("FAIL b2b_valid_cycles got=%0d want=%0d", nvalid, 2 * FL);
    end
    total++;
    if (col_m !== 16'hD0DD) begin
      bad++; $display("FAIL b2b_stream got=%h want=%h", col_m, 16'hD0DD);
    end
  endtask

  task automatic test_busy_pulse();
    logic [7:0] exp;
    int         nvalid;
    nvalid = 0;
    for (int k = 0; k < FL + 5; k++) begin
      drive(k == 0 || k == 3, (k == 0) ? 8'hD0 : 8'hFF);
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL busy_pulse cyc=%0d got=%b want=%b", k, w_obs, exp);
      end
      if (m_valid === 1'b1) nvalid++;
      model_step();
      @(posedge clk); #1;
    end
    total++;
    if (nvalid != FL) begin
      bad++; $display("FAIL busy_pulse_len got=%0d want=%0d", nvalid, FL);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp;
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 8'hD0);
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL midrst_pre cyc=%0d got=%b want=%b", k, w_obs, exp);
      end
      model_step();
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (w_obs !== 8'h00) begin
      bad++; $display("FAIL midrst_async got=%b want=%b", w_obs, 8'h00);
    end
    total++;
    if (m_state !== IDLE || l_state !== IDLE) begin
      bad++; $display("FAIL midrst_state got=%0d/%0d want=%0d", m_state, l_state, IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp = model_expect();
    total++;
    if (w_obs !== exp) begin
      bad++; $display("FAIL midrst_release got=%b want=%b", w_obs, exp);
    end
    @(posedge clk); #1;
    test_single_frame(8'hD0, 8'hD0, 8'h0B);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom));
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", k, w_obs, exp);
      end
      model_step();
      @(posedge clk); #1;
    end
    drive(1'b0, '0);
    for (int k = 0; k < FL + 2; k++) begin
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity_frame(input logic [W-1:0] word, input logic pbit);
    logic [7:0] exp;
    for (int k = 0; k < FL + 3; k++) begin
      drive(k == 0, word);
      @(negedge clk);
      exp = model_expect();
      total++;
      if (w_obs !== exp) begin
        bad++; $display("FAIL parity_%h cyc=%0d got=%b want=%b", word, k, w_obs, exp);
      end
      if (k == FL) begin
        total++;
        if ({m_out, m_fd, l_out, l_fd} !== {pbit, 1'b1, pbit, 1'b1}) begin
          bad++; $display("FAIL parity_bit_%h got=%b want=%b", word,
                          {m_out, m_fd, l_out, l_fd}, {pbit, 1'b1, pbit, 1'b1});
        end
      end
      model_step();
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame(8'hD0, 8'hD0, 8'h0B);
    test_single_frame(8'h0B, 8'h0B, 8'hD0);
    test_back_to_back();
    test_busy_pulse();
    test_reset_midframe();
`ifdef PISO_PARITY_EN
    test_parity_frame(8'hB1, 1'b0);
    test_parity_frame(8'h07, 1'b1);
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
